// File: rtl/sent_cmd_dispatch.sv
// SENT command dispatcher: parses UDP command frames and routes parameter
// updates and data words to the per-channel SENT transmitters.
module sent_cmd_dispatch #(
  parameter int unsigned SENT_NUM       = 2,
  parameter int unsigned ID_SENT_PARAM  = 2,
  parameter int unsigned ID_SENT_DATA   = 3,
  parameter int unsigned DATA_MAX_WORDS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         rx_axis_udp_tdata,
  input  logic                rx_axis_udp_tvalid,
  input  logic                rx_axis_udp_tlast,
  input  logic [SENT_NUM-1:0] sent_ready,
  input  logic [SENT_NUM-1:0] sent_fifo_pfull,
  output logic [SENT_NUM-1:0] cfg_wr,
  output logic [7:0]          cfg_ctick_len,
  output logic [7:0]          cfg_ltick_len,
  output logic [1:0]          cfg_pause_mode,
  output logic [15:0]         cfg_pause_len,
  output logic                cfg_crc_mode,
  output logic [SENT_NUM-1:0] fifo_wr,
  output logic [31:0]         fifo_wdata,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic [15:0]         err_cnt
);

  localparam int unsigned CH_W  = (SENT_NUM > 1) ? $clog2(SENT_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_MAX_WORDS + 1);

  localparam logic [1:0] ERR_ADDR  = 2'd1;
  localparam logic [1:0] ERR_BUSY  = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM1,
    S_PARAM2,
    S_DATA,
    S_DROP
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        p1_ctick;
  logic [7:0]        p1_ltick;
  logic [1:0]        p1_pmode;
  logic [7:0]        p1_plen_hi;

  logic [15:0]       hdr_id_c;
  logic [7:0]        hdr_ch_c;
  logic [CH_W-1:0]   hdr_idx_c;
  logic              is_param_c;
  logic              is_data_c;
  logic              ch_ok_c;
  logic [15:0]       plen_c;
  logic              range_ok_c;
  logic              cnt_full_c;
  logic              err_fire_c;
  logic [1:0]        err_val_c;
  logic              apply_c;

  // Header decode and parameter range checks on the current beat
  always_comb begin
    hdr_id_c   = rx_axis_udp_tdata[31:16];
    hdr_ch_c   = rx_axis_udp_tdata[15:8];
    hdr_idx_c  = CH_W'(hdr_ch_c);
    is_param_c = (hdr_id_c == 16'(ID_SENT_PARAM));
    is_data_c  = (hdr_id_c == 16'(ID_SENT_DATA));
    ch_ok_c    = ({24'd0, hdr_ch_c} < SENT_NUM);
    plen_c     = {p1_plen_hi, rx_axis_udp_tdata[31:24]};
    range_ok_c = (p1_ctick >= 8'd3) && (p1_ctick <= 8'd90) &&
                 (p1_ltick >= 8'd4) && (p1_pmode <= 2'd2) &&
                 ((p1_pmode == 2'd0) || ((plen_c >= 16'd12) && (plen_c <= 16'd768)));
    cnt_full_c = (cnt_q >= CNT_W'(DATA_MAX_WORDS));
  end

  // Per-beat drop/apply decision; an error is raised only once per frame
  always_comb begin
    err_fire_c = 1'b0;
    err_val_c  = 2'd0;
    apply_c    = 1'b0;
    if (rx_axis_udp_tvalid) begin
      unique case (state)
        S_IDLE: begin
          if (rx_axis_udp_tlast) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_FRAME;
          end else if ((!is_param_c && !is_data_c) || !ch_ok_c) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_ADDR;
          end else if (is_data_c && sent_fifo_pfull[hdr_idx_c]) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_BUSY;
          end
        end
        S_PARAM1: begin
          if (rx_axis_udp_tlast) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_FRAME;
          end
        end
        S_PARAM2: begin
          if (!rx_axis_udp_tlast || !range_ok_c) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_FRAME;
          end else if (!sent_ready[ch_q]) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_BUSY;
          end else begin
            apply_c = 1'b1;
          end
        end
        S_DATA: begin
          if (rx_axis_udp_tlast && cnt_full_c) begin
            err_fire_c = 1'b1;
            err_val_c  = ERR_FRAME;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame FSM with registered strobes, buses and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ch_q           <= '0;
      cnt_q          <= '0;
      p1_ctick       <= '0;
      p1_ltick       <= '0;
      p1_pmode       <= '0;
      p1_plen_hi     <= '0;
      cfg_wr         <= '0;
      cfg_ctick_len  <= '0;
      cfg_ltick_len  <= '0;
      cfg_pause_mode <= '0;
      cfg_pause_len  <= '0;
      cfg_crc_mode   <= 1'b0;
      fifo_wr        <= '0;
      fifo_wdata     <= '0;
      frame_err      <= 1'b0;
      err_code       <= '0;
      err_cnt        <= '0;
    end else begin
      cfg_wr    <= '0;
      fifo_wr   <= '0;
      frame_err <= err_fire_c;
      if (err_fire_c) begin
        err_code <= err_val_c;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (apply_c) begin
        cfg_wr         <= SENT_NUM'(1) << ch_q;
        cfg_ctick_len  <= p1_ctick;
        cfg_ltick_len  <= p1_ltick;
        cfg_pause_mode <= p1_pmode;
        cfg_pause_len  <= plen_c;
        cfg_crc_mode   <= rx_axis_udp_tdata[16];
      end
      if (rx_axis_udp_tvalid) begin
        unique case (state)
          S_IDLE: begin
            if (!rx_axis_udp_tlast) begin
              if (err_fire_c) begin
                state <= S_DROP;
              end else if (is_param_c) begin
                ch_q  <= hdr_idx_c;
                state <= S_PARAM1;
              end else begin
                ch_q  <= hdr_idx_c;
                cnt_q <= '0;
                state <= S_DATA;
              end
            end
          end
          S_PARAM1: begin
            p1_ctick   <= rx_axis_udp_tdata[31:24];
            p1_ltick   <= rx_axis_udp_tdata[23:16];
            p1_pmode   <= rx_axis_udp_tdata[9:8];
            p1_plen_hi <= rx_axis_udp_tdata[7:0];
            state      <= rx_axis_udp_tlast ? S_IDLE : S_PARAM2;
          end
          S_PARAM2: begin
            state <= rx_axis_udp_tlast ? S_IDLE : S_DROP;
          end
          S_DATA: begin
            // Overflow beats are swallowed; the count saturates at the limit
            if (!cnt_full_c) begin
              fifo_wr    <= SENT_NUM'(1) << ch_q;
              fifo_wdata <= rx_axis_udp_tdata;
              cnt_q      <= cnt_q + CNT_W'(1);
            end
            if (rx_axis_udp_tlast) state <= S_IDLE;
          end
          S_DROP: begin
            if (rx_axis_udp_tlast) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sent_cmd_dispatch.sv
// Self-checking bench for sent_cmd_dispatch: directed and randomized frames
// compared beat-by-beat against a frame-level reference model.
module tb_sent_cmd_dispatch;

  localparam int unsigned SN    = 2;
  localparam int unsigned ID_P  = 2;
  localparam int unsigned ID_D  = 3;
  localparam int unsigned MAXW  = 6;

  typedef logic [31:0] frame_t[$];

  typedef struct packed {
    logic [SN-1:0] cfg_wr;
    logic [34:0]   cfg;
    logic [SN-1:0] fifo_wr;
    logic [31:0]   wdata;
    logic          err;
    logic [1:0]    code;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tlast;
  logic [SN-1:0] sent_ready;
  logic [SN-1:0] sent_fifo_pfull;
  logic [SN-1:0] cfg_wr;
  logic [7:0]    cfg_ctick_len;
  logic [7:0]    cfg_ltick_len;
  logic [1:0]    cfg_pause_mode;
  logic [15:0]   cfg_pause_len;
  logic          cfg_crc_mode;
  logic [SN-1:0] fifo_wr;
  logic [31:0]   fifo_wdata;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [15:0]   err_cnt;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            gap_strobes = 0;
  beat_t         exp_a[];
  beat_t         obs_a[];
  logic [15:0]   m_err_cnt = '0;
  logic [34:0]   m_cfg = '0;

  sent_cmd_dispatch #(
    .SENT_NUM(SN), .ID_SENT_PARAM(ID_P), .ID_SENT_DATA(ID_D), .DATA_MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_axis_udp_tdata(tdata), .rx_axis_udp_tvalid(tvalid), .rx_axis_udp_tlast(tlast),
    .sent_ready(sent_ready), .sent_fifo_pfull(sent_fifo_pfull),
    .cfg_wr(cfg_wr), .cfg_ctick_len(cfg_ctick_len), .cfg_ltick_len(cfg_ltick_len),
    .cfg_pause_mode(cfg_pause_mode), .cfg_pause_len(cfg_pause_len), .cfg_crc_mode(cfg_crc_mode),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic frame_t param_frame(int id, int ch, int ct, int lt, int pm, int pl, int crc);
    frame_t f;
    f.push_back({16'(id), 8'(ch), 8'h00});
    f.push_back({8'(ct), 8'(lt), 6'd0, 2'(pm), 8'(pl >> 8)});
    f.push_back({8'(pl), 7'd0, 1'(crc), 16'd0});
    return f;
  endfunction

  function automatic frame_t data_frame(int id, int ch, frame_t pl);
    frame_t f;
    f.push_back({16'(id), 8'(ch), 8'h5A});
    foreach (pl[i]) f.push_back(pl[i]);
    return f;
  endfunction

  function automatic frame_t rand_payload(int n);
    frame_t p;
    for (int i = 0; i < n; i++) p.push_back($urandom);
    return p;
  endfunction

  function automatic void mark_err(int k, int c);
    exp_a[k].err  = 1'b1;
    exp_a[k].code = 2'(c);
    if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
  endfunction

  // Reference: whole-frame classification, outputs placed on the beat they answer
  function automatic void model_frame(frame_t w);
    int n  = w.size();
    int id = int'(w[0][31:16]);
    int ch = int'(w[0][15:8]);
    exp_a = new[n];
    foreach (exp_a[i]) exp_a[i] = '0;
    if (n == 1) mark_err(0, 3);
    else if ((id != ID_P && id != ID_D) || ch >= SN) mark_err(0, 1);
    else if (id == ID_P) begin
      if (n == 2) mark_err(1, 3);
      else if (n > 3) mark_err(2, 3);
      else begin
        int ct  = int'(w[1][31:24]);
        int lt  = int'(w[1][23:16]);
        int pm  = int'(w[1][9:8]);
        int pl  = int'({w[1][7:0], w[2][31:24]});
        int crc = int'(w[2][16]);
        if (ct < 3 || ct > 90 || lt < 4 || pm > 2 || (pm != 0 && (pl < 12 || pl > 768)))
          mark_err(2, 3);
        else if (!sent_ready[ch]) mark_err(2, 2);
        else begin
          m_cfg = {8'(ct), 8'(lt), 2'(pm), 16'(pl), 1'(crc)};
          exp_a[2].cfg_wr = SN'(1) << ch;
          exp_a[2].cfg    = m_cfg;
        end
      end
    end else if (sent_fifo_pfull[ch]) mark_err(0, 2);
    else begin
      for (int i = 1; i < n; i++)
        if (i <= MAXW) begin
          exp_a[i].fifo_wr = SN'(1) << ch;
          exp_a[i].wdata   = w[i];
        end
      if (n - 1 > MAXW) mark_err(n - 1, 3);
    end
  endfunction

  function automatic beat_t capture();
    beat_t b = '0;
    b.cfg_wr  = cfg_wr;
    if (|cfg_wr) b.cfg = {cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len, cfg_crc_mode};
    b.fifo_wr = fifo_wr;
    if (|fifo_wr) b.wdata = fifo_wdata;
    b.err     = frame_err;
    if (frame_err) b.code = err_code;
    return b;
  endfunction

  // Drive one frame (with optional idle gaps) and record the response to each beat
  task automatic run_frame(frame_t w, int gap_pct);
    obs_a = new[w.size()];
    foreach (w[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk); #1;
        if ((|cfg_wr) || (|fifo_wr) || frame_err) gap_strobes++;
      end
      tdata  = w[i];
      tvalid = 1'b1;
      tlast  = (i == w.size() - 1);
      @(posedge clk); #1;
      obs_a[i] = capture();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    sent_ready = '1; sent_fifo_pfull = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({cfg_wr, cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len, cfg_crc_mode,
         fifo_wr, fifo_wdata, frame_err, err_code, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs not all zero (cfg_wr=%b fifo_wr=%b err=%b cnt=%h wdata=%h)",
               cfg_wr, fifo_wr, frame_err, err_cnt, fifo_wdata);
    end
    rst = 1'b0;
    m_err_cnt = '0;
    m_cfg = '0;
  endtask

  task automatic test_param();
    frame_t f;
    sent_ready = 2'b11;
    f = param_frame(ID_P, 0, 10, 5, 1, 20, 0);
    model_frame(f);
    run_frame(f, 0);
    foreach (exp_a[i]) begin
      n_tests++;
      if (obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL param_ch0 beat %0d: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
    sent_ready = 2'b01;
    f = param_frame(ID_P, 1, 10, 5, 1, 20, 0);
    model_frame(f);
    run_frame(f, 0);
    foreach (exp_a[i]) begin
      n_tests++;
      if (obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL param_not_ready beat %0d: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== m_err_cnt || {cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len, cfg_crc_mode} !== m_cfg) begin
      n_fail++;
      $display("FAIL param_hold: err_cnt=%h cfg=%h expected err_cnt=%h cfg=%h", err_cnt,
               {cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len, cfg_crc_mode}, m_err_cnt, m_cfg);
    end
  endtask

  task automatic test_data();
    frame_t p = '{32'h6A654321, 32'h5A543210, 32'h4A432100, 32'h3A321000, 32'h2A210000, 32'h1A100000};
    frame_t f;
    sent_fifo_pfull = 2'b00;
    f = data_frame(ID_D, 1, p);
    for (int rep = 0; rep < 2; rep++) begin
      gap_strobes = 0;
      model_frame(f);
      run_frame(f, rep * 40);
      foreach (exp_a[i]) begin
        n_tests++;
        if (obs_a[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL data_ch1 rep %0d beat %0d: got %h expected %h", rep, i, obs_a[i], exp_a[i]);
        end
      end
      n_tests++;
      if (gap_strobes != 0) begin
        n_fail++;
        $display("FAIL data_gap_strobes rep %0d: got %0d expected 0", rep, gap_strobes);
      end
    end
    f = data_frame(ID_D, 0, rand_payload(8));
    model_frame(f);
    run_frame(f, 0);
    foreach (exp_a[i]) begin
      n_tests++;
      if (obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL data_overflow beat %0d: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_errors();
    frame_t bad[$];
    frame_t f;
    bad.push_back(param_frame(ID_P, 5, 10, 5, 1, 20, 0));
    bad.push_back(data_frame(7, 0, rand_payload(2)));
    bad.push_back(param_frame(ID_P, 0, 2, 5, 1, 20, 0));
    bad.push_back(param_frame(ID_P, 0, 10, 5, 3, 20, 0));
    f = param_frame(ID_P, 1, 10, 5, 1, 20, 1);
    void'(f.pop_back());
    bad.push_back(f);
    f = '{32'h0003_0000};
    bad.push_back(f);
    bad.push_back(data_frame(ID_D, 0, rand_payload(3)));
    sent_ready = 2'b11;
    foreach (bad[k]) begin
      sent_fifo_pfull = (k == bad.size() - 1) ? 2'b01 : 2'b00;
      model_frame(bad[k]);
      run_frame(bad[k], 0);
      foreach (exp_a[i]) begin
        n_tests++;
        if (obs_a[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL err_case %0d beat %0d: got %h expected %h", k, i, obs_a[i], exp_a[i]);
        end
      end
      f = param_frame(ID_P, k % 2, 3 + k, 4 + k, k % 3, 12 + 100 * k, k % 2);
      model_frame(f);
      run_frame(f, 0);
      foreach (exp_a[i]) begin
        n_tests++;
        if (obs_a[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL err_recover %0d beat %0d: got %h expected %h", k, i, obs_a[i], exp_a[i]);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== m_err_cnt) begin
      n_fail++;
      $display("FAIL err_count: got %h expected %h", err_cnt, m_err_cnt);
    end
  endtask

  task automatic test_back_to_back_random();
    frame_t f;
    int kind;
    gap_strobes = 0;
    for (int fr = 0; fr < 150; fr++) begin
      sent_ready      = SN'($urandom);
      sent_fifo_pfull = SN'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 4) begin
        int pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(12, 768));
        int ct = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(3, 90));
        int lt = int'($urandom_range(0, 40));
        f = param_frame(ID_P, int'($urandom_range(0, 2)), ct, lt, int'($urandom_range(0, 3)), pl, int'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) == 0) void'(f.pop_back());
        else if ($urandom_range(0, 9) == 0) f.push_back($urandom);
      end else if (kind < 8) begin
        f = data_frame(ID_D, int'($urandom_range(0, 2)), rand_payload(int'($urandom_range(0, 8))));
      end else begin
        f = data_frame(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), rand_payload(int'($urandom_range(0, 4))));
      end
      model_frame(f);
      run_frame(f, (fr % 2) * 25);
      foreach (exp_a[i]) begin
        n_tests++;
        if (obs_a[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL random frame %0d beat %0d: got %h expected %h", fr, i, obs_a[i], exp_a[i]);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== m_err_cnt || gap_strobes != 0) begin
      n_fail++;
      $display("FAIL random_totals: err_cnt=%h gap_strobes=%0d expected err_cnt=%h gap_strobes=0",
               err_cnt, gap_strobes, m_err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    sent_fifo_pfull = 2'b00;
    sent_ready      = 2'b11;
    f = data_frame(ID_D, 0, '{32'h11110001, 32'h22220002});
    tvalid = 1'b1;
    tlast  = 1'b0;
    foreach (f[i]) begin
      tdata = f[i];
      @(posedge clk); #1;
    end
    n_tests++;
    if (fifo_wr !== 2'b01 || fifo_wdata !== 32'h22220002) begin
      n_fail++;
      $display("FAIL midframe_pre: fifo_wr=%b wdata=%h expected 01/22220002", fifo_wr, fifo_wdata);
    end
    tdata = 32'h33330003;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    tvalid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (fifo_wr !== 2'b00 || cfg_wr !== 2'b00 || fifo_wdata !== 32'h0 || err_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL midframe_after_reset: fifo_wr=%b cfg_wr=%b wdata=%h err_cnt=%h expected all 0",
               fifo_wr, cfg_wr, fifo_wdata, err_cnt);
    end
    m_err_cnt = '0;
    m_cfg     = '0;
    f = '{32'h44440004};
    model_frame(f);
    run_frame(f, 0);
    foreach (exp_a[i]) begin
      n_tests++;
      if (obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL midframe_remainder beat %0d: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
    f = param_frame(ID_P, 1, 90, 200, 2, 768, 1);
    model_frame(f);
    run_frame(f, 0);
    foreach (exp_a[i]) begin
      n_tests++;
      if (obs_a[i] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL midframe_param beat %0d: got %h expected %h", i, obs_a[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_param();
    test_data();
    test_errors();
    test_back_to_back_random();
    test_reset_midframe();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
